exp_df_half_adder: RTL and testbench
====================================

// Module: exp_df_half_adder
// PURPOSE
//   Dataflow half adder with a registered output stage. Adds two WIDTH-bit
//     operands A and B bitwise, with no carry propagation between bits:
//     sum[i] = A[i] ^ B[i], carry[i] = A[i] & B[i].
//   Leaf arithmetic cell. Used as the building block for full adders and
//     ripple chains, and as the reference half-adder for modelling-style
//     comparisons.
// PARAMETERS
//   WIDTH   1   operand width; each bit position is an independent half adder
// PORTS
//   Positional order: clk, rst, sum, carry, A, B.
//   One clock; reset is synchronous and active-high.
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   sum    out  WIDTH  registered A ^ B
//   carry  out  WIDTH  registered A & B
//   A      in   WIDTH  operand A
//   B      in   WIDTH  operand B
// BEHAVIOUR
//   - Combinational core:
//       s_next = A ^ B
//       c_next = A & B
//   - Output registers update on every rising clk edge:
//       sum <= s_next, carry <= c_next
//   - Latency: exactly 1 clk. No enable, no handshake; inputs are sampled
//     every cycle.
//   - Reset:
//       rst = 1 at a rising edge -> sum = 0 and carry = 0 after that edge,
//         regardless of A and B.
//       Reset has priority over data.
//       Reset mid-operation discards the in-flight result.
//       The first edge with rst = 0 loads the current A and B.
//   - No reset is applied at power-up by the RTL. Outputs are X until the
//     first reset or data edge.
//   - Truth table, per bit (A B -> sum carry): 00->00, 01->10, 10->10, 11->01.
//   - sum and carry are never both 1 in the same bit.
//   - Width rules:
//       No overflow or wrap-around; there is no cross-bit carry.
//       {carry[i], sum[i]} equals A[i] + B[i] as a 2-bit value.
//   - Input changes between edges have no effect on the outputs until the
//     next edge (glitch-free outputs).
// STRUCTURE
//   - No shared package is needed. WIDTH is the only configuration.
//   - One natural sub-module: ha_bit, a purely combinational 1-bit cell
//     (s = a ^ b, c = a & b), instantiated WIDTH times in a generate loop.
//   - The top level holds only the generate loop and the output registers.
//   - ha_bit is written in continuous-assignment dataflow style.
// TESTING
//   Clock period 10, WIDTH = 1 unless stated. Results are checked one edge
//   after the input is applied.
//   1. rst = 1 for 2 edges with A = 1, B = 1 -> sum = 0, carry = 0 while
//      reset is asserted.
//   2. Release rst; apply A,B = 00, 01, 10, 11, holding each for 5 edges.
//      Required sum,carry one edge later: 00, 10, 10, 01.
//   3. Latency: hold A = 1, B = 0, then change to A = 1, B = 1 between
//      edges. sum stays 1 until the next edge, then sum = 0, carry = 1.
//   4. Reset mid-operation with A = 1, B = 1 and rst = 1 for 1 edge ->
//      outputs 00. Release rst -> outputs 01 after the following edge.
//   5. WIDTH = 4, A = 4'b1100, B = 4'b1010 -> sum = 4'b0110,
//      carry = 4'b1000 after 1 edge.
//   6. Random A and B for 200 edges at WIDTH = 4. Scoreboard checks
//      sum == prev(A ^ B) and carry == prev(A & B), and that
//      (sum & carry) == 0.

Source files
------------

// File: rtl/exp_df_half_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp_df_half_adder_pkg
//  Description : Shared types and constants for the dataflow half adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package exp_df_half_adder_pkg;

   // Default operand width. Each bit is an independent half-adder cell.
   localparam int unsigned c_DEFAULT_WIDTH = 1;

   // Result of one half-adder cell. {c, s} is the 2-bit sum of the inputs.
   typedef struct packed {
      logic c;
      logic s;
   } ha_res_t;

endpackage : exp_df_half_adder_pkg
`default_nettype wire

// File: rtl/exp_df_half_adder_ha_bit.sv
`default_nettype none
// ============================================================================
//  Module      : ha_bit
//  Description : Purely combinational 1-bit half adder (s = a ^ b, c = a & b).
//  Revision    : 1.0 - initial release
// ============================================================================
module ha_bit (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Sum is the parity of the inputs; carry is set only when both are 1.
   assign s = a ^ b;
   assign c = a & b;

endmodule : ha_bit
`default_nettype wire

// File: rtl/exp_df_half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : exp_df_half_adder
//  Description : WIDTH independent half adders with a registered output stage.
//                No carry crosses bit boundaries. Latency is one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_df_half_adder
   import exp_df_half_adder_pkg::*;
#(
   parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B
);

   ha_res_t [WIDTH-1:0] w_res;

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] carry_d;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;

   // One combinational cell per bit position.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ha_bit u_ha_bit (
         .a (A[i]),
         .b (B[i]),
         .s (w_res[i].s),
         .c (w_res[i].c)
      );
   end : g_bit

   // Gather the per-bit results into the next-state vectors.
   always_comb begin
      sum_d   = '0;
      carry_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum_d[i]   = w_res[i].s;
         carry_d[i] = w_res[i].c;
      end
   end

   // Output registers: reset wins over data, otherwise load every edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= '0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign sum   = sum_q;
   assign carry = carry_q;

endmodule : exp_df_half_adder
`default_nettype wire

// File: tb/tb_exp_df_half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_df_half_adder
//  Description : Self-checking bench for exp_df_half_adder at WIDTH 1 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_df_half_adder;

   logic       clk;
   logic       rst;
   logic [0:0] a1, b1, sum1, carry1;
   logic [3:0] a4, b4, sum4, carry4;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the outputs must show after the last edge.
   logic [0:0] m_sum1, m_carry1;
   logic [3:0] m_sum4, m_carry4;
   bit         m_known = 0;

   exp_df_half_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .sum   (sum1),
      .carry (carry1),
      .A     (a1),
      .B     (b1)
   );

   exp_df_half_adder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .sum   (sum4),
      .carry (carry4),
      .A     (a4),
      .B     (b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each bit pair is added as integers; bit 0 of the 2-bit result
   // is the sum, bit 1 is the carry.
   always @(posedge clk) begin
      if (rst) begin
         m_sum1 = '0; m_carry1 = '0; m_sum4 = '0; m_carry4 = '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            int t;
            t = int'(a4[i]) + int'(b4[i]);
            m_sum4[i]   = (t % 2) != 0;
            m_carry4[i] = (t / 2) != 0;
         end
         begin
            int t1;
            t1 = int'(a1[0]) + int'(b1[0]);
            m_sum1[0]   = (t1 % 2) != 0;
            m_carry1[0] = (t1 / 2) != 0;
         end
      end
      m_known = 1;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_known) begin
         check("cmp_sum1",   {3'b0, sum1},   {3'b0, m_sum1});
         check("cmp_carry1", {3'b0, carry1}, {3'b0, m_carry1});
         check("cmp_sum4",   sum4,   m_sum4);
         check("cmp_carry4", carry4, m_carry4);
         check("cmp_exclusive4", sum4 & carry4, 4'b0000);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Stimulus with hand-computed literal expectations.
   initial begin
      logic [1:0] pat;
      logic [3:0] lit_s [4];
      logic [3:0] lit_c [4];
      lit_s = '{4'd0, 4'd1, 4'd1, 4'd0};
      lit_c = '{4'd0, 4'd0, 4'd0, 4'd1};

      // Reset held for two edges with both operands high.
      rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      tick(); tick();
      check("rst_sum1",   {3'b0, sum1},   4'd0);
      check("rst_carry1", {3'b0, carry1}, 4'd0);
      check("rst_sum4",   sum4,   4'd0);
      check("rst_carry4", carry4, 4'd0);

      // Truth table, each pattern held five edges.
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
         pat = 2'(p);
         a1 = pat[1]; b1 = pat[0];
         a4 = 4'($urandom); b4 = 4'($urandom);
         repeat (5) tick();
         check("tt_sum1",   {3'b0, sum1},   lit_s[p]);
         check("tt_carry1", {3'b0, carry1}, lit_c[p]);
      end

      // Latency: input change between edges is invisible until next edge.
      a1 = 1'b1; b1 = 1'b0;
      tick();
      check("lat_sum_before", {3'b0, sum1}, 4'd1);
      #4 b1 = 1'b1;
      #1;
      check("lat_sum_hold",   {3'b0, sum1},   4'd1);
      check("lat_carry_hold", {3'b0, carry1}, 4'd0);
      tick();
      check("lat_sum_after",   {3'b0, sum1},   4'd0);
      check("lat_carry_after", {3'b0, carry1}, 4'd1);

      // Reset mid-operation discards the in-flight result.
      rst = 1'b1;
      tick();
      check("mid_rst_sum",   {3'b0, sum1},   4'd0);
      check("mid_rst_carry", {3'b0, carry1}, 4'd0);
      rst = 1'b0;
      tick();
      check("post_rst_sum",   {3'b0, sum1},   4'd0);
      check("post_rst_carry", {3'b0, carry1}, 4'd1);

      // Four-bit directed vector.
      a4 = 4'b1100; b4 = 4'b1010;
      tick();
      check("w4_sum",   sum4,   4'b0110);
      check("w4_carry", carry4, 4'b1000);

      // Random traffic, checked every cycle by the compare process.
      repeat (200) begin
         a4 = 4'($urandom); b4 = 4'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule : tb_exp_df_half_adder
`default_nettype wire
